// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encodings and default parameters for the debouncer
//
// Purpose : per-channel FSM state encodings and default parameter values used by
//           debounce_channel and three_input_debouncer.
// Ports   : none (package).
package debounce_pkg;

    // 2-bit channel FSM encodings
    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI   = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO   = 2'd3;

    // Default parameter values
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, stability counter and FSM for one raw input
//
// Purpose : brings one asynchronous level into the clk domain and only passes a
//           new level once it has held for DEBOUNCE_CYCLES consecutive cycles.
// Ports   : clk          - rising-edge clock
//           reset        - asynchronous active-high reset
//           raw_i        - raw asynchronous level
//           level_o      - registered debounced level
//           level_next_o - next-state value of level_o (lets the top build strobes
//                          that are registered in step with level_o)
import debounce_pkg::*;

module debounce_channel #(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic level_next_o
);

    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
    // With a one-cycle requirement the first stable sample already qualifies,
    // so the WAIT state is skipped entirely.
    localparam bit SINGLE_CYCLE = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   level_q, level_d;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // Saturating increment: the count is held at DEB_CNT rather than wrapping.
    assign cnt_inc = (cnt_q >= DEB_CNT) ? DEB_CNT : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            STABLE_LO: begin
                if (sync) begin
                    if (SINGLE_CYCLE) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_CNT) begin
                    state_d = STABLE_HI;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            STABLE_HI: begin
                if (!sync) begin
                    if (SINGLE_CYCLE) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            default: begin // WAIT_LO
                if (sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_CNT) begin
                    state_d = STABLE_LO;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o      = level_q;
    assign level_next_o = level_d;

endmodule

// File: rtl/three_input_debouncer.sv
// rtl/three_input_debouncer.sv - three independent debounced levels with a change strobe
//
// Purpose : debounces a_in/b_in/c_in and flags the cycle in which any output moves.
// Config  : define DEBOUNCER_EDGE_EN to add the per-channel rise[2:0] pulse output.
// Ports   : clk        - rising-edge clock
//           reset      - asynchronous active-high reset
//           a_in/b_in/c_in - raw asynchronous levels
//           a/b/c      - registered debounced levels
//           changed    - one-cycle strobe coincident with any output change
//           rise[2:0]  - (DEBOUNCER_EDGE_EN only) 0->1 pulse per output, bit0=a
import debounce_pkg::*;

module three_input_debouncer #(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_in,
    input  logic       b_in,
    input  logic       c_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       changed
`ifdef DEBOUNCER_EDGE_EN
    ,
    output logic [2:0] rise
`endif
);

    logic [2:0] raw;
    logic [2:0] lvl_q;
    logic [2:0] lvl_d;
    logic       changed_q;

    assign raw = {c_in, b_in, a_in};

    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_a (.clk(clk), .reset(reset), .raw_i(raw[0]), .level_o(lvl_q[0]), .level_next_o(lvl_d[0]));
    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_b (.clk(clk), .reset(reset), .raw_i(raw[1]), .level_o(lvl_q[1]), .level_next_o(lvl_d[1]));
    debounce_channel #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W))
        u_c (.clk(clk), .reset(reset), .raw_i(raw[2]), .level_o(lvl_q[2]), .level_next_o(lvl_d[2]));

    // Strobes are computed from next-vs-current so that, once registered, they
    // sit in the same cycle as the new output value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |(lvl_d ^ lvl_q);
        end
    end

`ifdef DEBOUNCER_EDGE_EN
    logic [2:0] rise_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= lvl_d & ~lvl_q;
        end
    end

    assign rise = rise_q;
`endif

    assign a       = lvl_q[0];
    assign b       = lvl_q[1];
    assign c       = lvl_q[2];
    assign changed = changed_q;

endmodule

// File: tb/tb_three_input_debouncer.sv
// tb/tb_three_input_debouncer.sv - directed self-checking bench for three_input_debouncer
module tb_three_input_debouncer;

    logic clk = 1'b0;
    logic reset;
    logic a_in, b_in, c_in;
    logic a, b, c, changed;
`ifdef DEBOUNCER_EDGE_EN
    logic [2:0] rise;
`endif

    int checks   = 0;
    int failures = 0;

    three_input_debouncer dut (
        .clk     (clk),
        .reset   (reset),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
        .a       (a),
        .b       (b),
        .c       (c),
        .changed (changed)
`ifdef DEBOUNCER_EDGE_EN
        ,
        .rise    (rise)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        reset = 1'b1;
        a_in = 1'b1; b_in = 1'b1; c_in = 1'b1;
        repeat (3) tick();
        checks++;
        if ({a, b, c, changed} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {a, b, c, changed});
        end
        checks++;
        if (dut.u_a.state_q !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", dut.u_a.state_q);
        end
        // Release with all inputs high: outputs rise together on edge 6.
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k >= 6) ? 4'b1110 : 4'b0000;
            if (k == 6) exp[0] = 1'b1;
            checks++;
            if ({a, b, c, changed} !== exp) begin
                failures++;
                $display("FAIL release_edge%0d got=%b exp=%b", k, {a, b, c, changed}, exp);
            end
        end
        a_in = 1'b0; b_in = 1'b0; c_in = 1'b0;
        repeat (10) tick();
        checks++;
        if ({a, b, c, changed} !== 4'b0000) begin
            failures++;
            $display("FAIL fall_back got=%b exp=0000", {a, b, c, changed});
        end
    endtask

    task automatic test_glitch_a();
        a_in = 1'b1;
        repeat (3) tick();
        a_in = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if ({a, changed} !== 2'b00) begin
                failures++;
                $display("FAIL glitch_a_cyc%0d got=%b exp=00", k, {a, changed});
            end
            tick();
        end
    endtask

    task automatic test_b_rise();
        logic [3:0] exp;
        b_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = {1'b0, (k >= 6), 1'b0, (k == 6)};
            checks++;
            if ({a, b, c, changed} !== exp) begin
                failures++;
                $display("FAIL b_rise_edge%0d got=%b exp=%b", k, {a, b, c, changed}, exp);
            end
        end
    endtask

    task automatic test_c_glitch();
        c_in = 1'b1;
        repeat (8) tick();
        checks++;
        if (c !== 1'b1) begin
            failures++;
            $display("FAIL c_settled got=%b exp=1", c);
        end
        c_in = 1'b0;
        repeat (2) tick();
        c_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if ({c, changed} !== 2'b10) begin
                failures++;
                $display("FAIL c_glitch_cyc%0d got=%b exp=10", k, {c, changed});
            end
            tick();
        end
        checks++;
        if (dut.u_c.state_q !== 2'd2) begin
            failures++;
            $display("FAIL c_state got=%0d exp=2", dut.u_c.state_q);
        end
    endtask

    task automatic test_reset_mid_wait();
        // b and c are high here, so an async reset must visibly drop them.
        a_in = 1'b1;
        repeat (4) tick();
        checks++;
        if (dut.u_a.state_q !== 2'd1) begin
            failures++;
            $display("FAIL a_wait_hi got=%0d exp=1", dut.u_a.state_q);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a, b, c, changed, dut.u_a.state_q, dut.u_a.cnt_q} !== {4'b0000, 2'd0, 8'd0}) begin
            failures++;
            $display("FAIL async_reset got=%b st=%0d cnt=%0d exp=0000 st=0 cnt=0",
                     {a, b, c, changed}, dut.u_a.state_q, dut.u_a.cnt_q);
        end
        a_in = 1'b0; b_in = 1'b0; c_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if ({a, b, c, changed} !== 4'b0000) begin
                failures++;
                $display("FAIL post_reset_cyc%0d got=%b exp=0000", k, {a, b, c, changed});
            end
        end
    endtask

`ifdef DEBOUNCER_EDGE_EN
    task automatic test_edge();
        logic [3:0] exp;
        checks++;
        if (rise !== 3'b000) begin
            failures++;
            $display("FAIL rise_idle got=%b exp=000", rise);
        end
        a_in = 1'b1; c_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k == 6) ? 4'b1011 : 4'b0000;
            checks++;
            if ({rise, changed} !== exp) begin
                failures++;
                $display("FAIL rise_edge%0d got=%b exp=%b", k, {rise, changed}, exp);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        a_in = 1'b0; b_in = 1'b0; c_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_glitch_a();
        test_b_rise();
        test_c_glitch();
        test_reset_mid_wait();
`ifdef DEBOUNCER_EDGE_EN
        test_edge();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
